// File: rtl/mmio_pkg.sv
// Shared register-map constants for the MMIO port bank and its interval timer.
package mmio_pkg;

    localparam int WINDOW_BITS = 5;

    localparam logic [WINDOW_BITS-1:0] OFF_CTRL   = 5'h08;
    localparam logic [WINDOW_BITS-1:0] OFF_STATUS = 5'h09;
    localparam logic [WINDOW_BITS-1:0] OFF_RLD_LO = 5'h0a;
    localparam logic [WINDOW_BITS-1:0] OFF_RLD_HI = 5'h0b;
    localparam logic [WINDOW_BITS-1:0] OFF_CNT_LO = 5'h0c;
    localparam logic [WINDOW_BITS-1:0] OFF_CNT_HI = 5'h0d;
    localparam logic [WINDOW_BITS-1:0] OFF_CYC    = 5'h10;

    localparam int CTRL_IRQ_SW = 0;
    localparam int CTRL_NMI_SW = 1;
    localparam int CTRL_TMR_EN = 2;
    localparam int CTRL_TMR_IE = 3;

endpackage

// File: rtl/mmio_interval_timer.sv
// 16-bit down-counting interval timer with auto-reload and a sticky underflow flag.
module mmio_interval_timer
    import mmio_pkg::*;
#(
    parameter logic [15:0] TIMER_RESET = 16'hffff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        wr_rld_lo,
    input  logic        wr_rld_hi,
    input  logic        clr_flag,
    input  logic [7:0]  wdata,
    output logic [15:0] reload_o,
    output logic [15:0] count_o,
    output logic        flag_o
);

    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic        underflow;

    always_comb begin
        reload_d  = reload_q;
        count_d   = count_q;
        flag_d    = flag_q;
        underflow = 1'b0;
        if (wr_rld_lo) reload_d[7:0] = wdata;
        // A high-byte write restarts the count and takes priority over counting.
        if (wr_rld_hi) begin
            reload_d[15:8] = wdata;
            count_d        = {wdata, reload_q[7:0]};
        end else if (en) begin
            if (count_q == 16'd0) begin
                count_d   = reload_q;
                underflow = 1'b1;
            end else begin
                count_d = count_q - 16'd1;
            end
        end
        if (clr_flag) flag_d = 1'b0;
        if (underflow) flag_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_q <= TIMER_RESET;
            count_q  <= TIMER_RESET;
            flag_q   <= 1'b0;
        end else begin
            reload_q <= reload_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    assign reload_o = reload_q;
    assign count_o  = count_q;
    assign flag_o   = flag_q;

endmodule

// File: rtl/mmio_port_bank.sv
// 6502-bus MMIO block: R/W output ports, irq/nmi control, interval timer and a
// free-running cycle counter with a coherent multi-byte snapshot.
module mmio_port_bank
    import mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hbfe0,
    parameter int          NUM_PORTS   = 4,
    parameter int          CNT_W       = 32,
    parameter logic [15:0] TIMER_RESET = 16'hffff
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ready,
    input  logic [15:0]            addr_next,
    input  logic                   we_next,
    input  logic [7:0]             data_i,
    output logic [7:0]             data_o,
    output logic                   cs_o,
    output logic [NUM_PORTS*8-1:0] port_o,
    output logic [NUM_PORTS-1:0]   port_wr_o,
    output logic                   irq,
    output logic                   nmi
);

    logic                   hit, wr, rd;
    logic [4:0]             off;
    logic [NUM_PORTS*8-1:0] port_q, port_d;
    logic [NUM_PORTS-1:0]   port_wr_q, port_wr_d;
    logic [3:0]             ctrl_q, ctrl_d;
    logic [CNT_W-1:0]       cyc_q, cyc_d;
    logic [CNT_W-1:0]       shadow_q, shadow_d;
    logic [7:0]             data_q, data_d;
    logic                   cs_q, cs_d;
    logic [7:0]             rdata;
    logic [15:0]            tmr_reload, tmr_count;
    logic                   tmr_flag;

    assign hit = (addr_next[15:WINDOW_BITS] == BASE_ADDR[15:WINDOW_BITS]);
    assign off = addr_next[WINDOW_BITS-1:0];
    assign wr  = hit & we_next & ready;
    assign rd  = hit & ~we_next & ready;

    mmio_interval_timer #(
        .TIMER_RESET(TIMER_RESET)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (ctrl_q[CTRL_TMR_EN]),
        .wr_rld_lo(wr && (off == OFF_RLD_LO)),
        .wr_rld_hi(wr && (off == OFF_RLD_HI)),
        .clr_flag (wr && (off == OFF_STATUS) && data_i[0]),
        .wdata    (data_i),
        .reload_o (tmr_reload),
        .count_o  (tmr_count),
        .flag_o   (tmr_flag)
    );

    always_comb begin
        port_d    = port_q;
        port_wr_d = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr && (off == 5'(i))) begin
                port_d[8*i +: 8] = data_i;
                port_wr_d[i]     = 1'b1;
            end
        end
        ctrl_d = ctrl_q;
        if (wr && (off == OFF_CTRL)) ctrl_d = data_i[3:0];
        cyc_d    = cyc_q + CNT_W'(1);
        shadow_d = shadow_q;
        if (rd && (off == OFF_CYC)) shadow_d = cyc_q;
    end

    // Read mux sees pre-update register values, so a write returns old data.
    always_comb begin
        rdata = 8'h00;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (off == 5'(i)) rdata = port_q[8*i +: 8];
        end
        case (off)
            OFF_CTRL:   rdata = {4'b0000, ctrl_q};
            OFF_STATUS: rdata = {7'b0000000, tmr_flag};
            OFF_RLD_LO: rdata = tmr_reload[7:0];
            OFF_RLD_HI: rdata = tmr_reload[15:8];
            OFF_CNT_LO: rdata = tmr_count[7:0];
            OFF_CNT_HI: rdata = tmr_count[15:8];
            default:    ;
        endcase
        for (int b = 0; b < CNT_W/8; b++) begin
            if (off == (OFF_CYC + 5'(b))) begin
                rdata = (b == 0) ? cyc_q[8*b +: 8] : shadow_q[8*b +: 8];
            end
        end
        data_d = ready ? rdata : data_q;
        cs_d   = ready ? hit : cs_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_q    <= '0;
            port_wr_q <= '0;
            ctrl_q    <= '0;
            cyc_q     <= '0;
            shadow_q  <= '0;
            data_q    <= '0;
            cs_q      <= 1'b0;
        end else begin
            port_q    <= port_d;
            port_wr_q <= port_wr_d;
            ctrl_q    <= ctrl_d;
            cyc_q     <= cyc_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            cs_q      <= cs_d;
        end
    end

    assign data_o    = data_q;
    assign cs_o      = cs_q;
    assign port_o    = port_q;
    assign port_wr_o = port_wr_q;
    assign irq       = ctrl_q[CTRL_IRQ_SW] | (tmr_flag & ctrl_q[CTRL_TMR_IE]);
    assign nmi       = ctrl_q[CTRL_NMI_SW];

endmodule
